// File: rtl/mastermind_feedback_pkg.sv
// Shared widths, colour codes, FSM encoding and peg helpers
// for the mastermind scoring stage.
package mastermind_feedback_pkg;

  localparam int COLOR_W  = 3;
  localparam int N_PEGS   = 4;
  localparam int N_ROWS   = 6;
  localparam int N_COLORS = 6;
  localparam int CODE_W   = N_PEGS * COLOR_W;
  localparam int SLOT_W   = 6;
  localparam int FB_W     = N_ROWS * SLOT_W;

  localparam logic [COLOR_W-1:0] COLOR_EMPTY = 3'd0;
  localparam logic [COLOR_W-1:0] LAST_COLOR  = 3'(N_COLORS);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_EXACT  = 2'd1;
  localparam logic [1:0] S_COLOR  = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  function automatic logic [COLOR_W-1:0] peg(
    input logic [CODE_W-1:0] code,
    input int                i
  );
    return code[i*COLOR_W +: COLOR_W];
  endfunction

  function automatic logic is_color(input logic [COLOR_W-1:0] c);
    return (c != COLOR_EMPTY) && (c <= LAST_COLOR);
  endfunction

endpackage

// File: rtl/mastermind_feedback_if.sv
// Request/result bundle between mastermind_core (master)
// and the feedback scorer (slave).
interface mastermind_feedback_if;
  import mastermind_feedback_pkg::*;

  logic              clear;
  logic              start;
  logic [CODE_W-1:0] guess;
  logic [CODE_W-1:0] answer;
  logic [2:0]        row;
  logic              busy;
  logic              done;
  logic [2:0]        exact;
  logic [2:0]        partial;
  logic              win;
  logic [FB_W-1:0]   feedback_flat;

  modport master (
    output clear, start, guess, answer, row,
    input  busy, done, exact, partial, win, feedback_flat
  );

  modport slave (
    input  clear, start, guess, answer, row,
    output busy, done, exact, partial, win, feedback_flat
  );

endinterface

// File: rtl/mastermind_color_count.sv
// Counts how many pegs of a packed code carry a given colour.
// Purely combinational; one instance per code.
module mastermind_color_count
  import mastermind_feedback_pkg::*;
(
  input  logic [CODE_W-1:0]  i_code,
  input  logic [COLOR_W-1:0] i_color,
  output logic [2:0]         o_count
);

  always_comb begin
    o_count = 3'd0;
    for (int i = 0; i < N_PEGS; i++) begin
      if (peg(i_code, i) == i_color)
        o_count = o_count + 3'd1;
    end
  end

endmodule

// File: rtl/mastermind_feedback.sv
// Guess scorer: exact count in one cycle, then one colour per
// cycle for the colour-match total; fixed 8-cycle latency.
module mastermind_feedback
  import mastermind_feedback_pkg::*;
(
  input  logic                 Clk,
  input  logic                 Reset,
  mastermind_feedback_if.slave bus
);

  logic [1:0]         r_state;
  logic [CODE_W-1:0]  r_guess;
  logic [CODE_W-1:0]  r_answer;
  logic [2:0]         r_row;
  logic [2:0]         r_exact_r;
  logic [2:0]         r_total;
  logic [COLOR_W-1:0] r_c;
  logic [2:0]         r_exact;
  logic [2:0]         r_partial;
  logic               r_done;
  logic               r_win;
  logic [FB_W-1:0]    r_fb;

  logic [2:0] w_cnt_g;
  logic [2:0] w_cnt_a;
  logic [2:0] w_min;
  logic [2:0] w_exact;
  logic [2:0] w_partial;

  mastermind_color_count u_cnt_g (
    .i_code  (r_guess),
    .i_color (r_c),
    .o_count (w_cnt_g)
  );

  mastermind_color_count u_cnt_a (
    .i_code  (r_answer),
    .i_color (r_c),
    .o_count (w_cnt_a)
  );

  assign w_min = (w_cnt_g < w_cnt_a) ? w_cnt_g : w_cnt_a;

  // Empty (0) and invalid (7) pegs never count as exact hits
  always_comb begin
    w_exact = 3'd0;
    for (int i = 0; i < N_PEGS; i++) begin
      if (peg(r_guess, i) == peg(r_answer, i) &&
          is_color(peg(r_guess, i)))
        w_exact = w_exact + 3'd1;
    end
  end

  assign w_partial = r_total - r_exact_r;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state   <= S_IDLE;
      r_guess   <= '0;
      r_answer  <= '0;
      r_row     <= '0;
      r_exact_r <= '0;
      r_total   <= '0;
      r_c       <= '0;
      r_exact   <= '0;
      r_partial <= '0;
      r_done    <= 1'b0;
      r_win     <= 1'b0;
      r_fb      <= '0;
    end else if (bus.clear) begin
      r_state   <= S_IDLE;
      r_exact_r <= '0;
      r_total   <= '0;
      r_c       <= '0;
      r_exact   <= '0;
      r_partial <= '0;
      r_done    <= 1'b0;
      r_win     <= 1'b0;
      r_fb      <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_guess  <= bus.guess;
            r_answer <= bus.answer;
            r_row    <= bus.row;
            r_state  <= S_EXACT;
          end
        end
        S_EXACT: begin
          r_exact_r <= w_exact;
          r_total   <= 3'd0;
          r_c       <= 3'd1;
          r_state   <= S_COLOR;
        end
        S_COLOR: begin
          r_total <= r_total + w_min;
          r_c     <= r_c + 3'd1;
          if (r_c == LAST_COLOR)
            r_state <= S_FINISH;
        end
        S_FINISH: begin
          r_exact   <= r_exact_r;
          r_partial <= w_partial;
          r_done    <= 1'b1;
          r_win     <= (r_exact_r == 3'd4);
          for (int r = 0; r < N_ROWS; r++) begin
            if (r_row == 3'(r))
              r_fb[r*SLOT_W +: SLOT_W] <= {r_exact_r, w_partial};
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy          = (r_state != S_IDLE);
  assign bus.done          = r_done;
  assign bus.exact         = r_exact;
  assign bus.partial       = r_partial;
  assign bus.win           = r_win;
  assign bus.feedback_flat = r_fb;

endmodule

// File: tb/tb_mastermind_feedback.sv
// Directed plus randomized bench for mastermind_feedback with a
// colour-histogram reference model.
module tb_mastermind_feedback;
  import mastermind_feedback_pkg::*;

  logic Clk = 1'b0;
  logic Reset;

  always #5 Clk = ~Clk;

  mastermind_feedback_if bus ();

  mastermind_feedback dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [35:0] m_fb;
  logic        m_win;
  logic [2:0]  m_ex;
  logic [2:0]  m_pa;

  task automatic chk(input string tag, input logic [35:0] obs,
                     input logic [35:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void ref_score(input logic [11:0] g,
                                    input logic [11:0] a,
                                    output logic [2:0] ex,
                                    output logic [2:0] pa);
    int cg[8];
    int ca[8];
    int e;
    int tot;
    logic [2:0] gi;
    logic [2:0] ai;
    e = 0;
    tot = 0;
    for (int c = 0; c < 8; c++) begin
      cg[c] = 0;
      ca[c] = 0;
    end
    for (int i = 0; i < 4; i++) begin
      gi = g[i*3 +: 3];
      ai = a[i*3 +: 3];
      if (gi == ai && gi >= 3'd1 && gi <= 3'd6) e++;
      cg[gi]++;
      ca[ai]++;
    end
    for (int c = 1; c <= 6; c++)
      tot += (cg[c] < ca[c]) ? cg[c] : ca[c];
    ex = 3'(e);
    pa = 3'(tot - e);
  endfunction

  task automatic eval(input logic [11:0] g, input logic [11:0] a,
                      input logic [2:0] r, input bit extra);
    int ndone;
    int at;
    ndone = 0;
    at = 0;
    @(negedge Clk);
    bus.guess  = g;
    bus.answer = a;
    bus.row    = r;
    bus.start  = 1'b1;
    @(posedge Clk);
    #1;
    chk("busy_after_start", 36'(bus.busy), 36'd1);
    for (int n = 1; n <= 10; n++) begin
      @(negedge Clk);
      bus.start  = extra && (n == 3);
      bus.guess  = 12'($urandom);
      bus.answer = 12'($urandom);
      bus.row    = 3'($urandom);
      @(posedge Clk);
      #1;
      if (bus.done) begin
        ndone++;
        at = n;
      end
    end
    ref_score(g, a, m_ex, m_pa);
    if (r < 3'd6) m_fb[int'(r)*6 +: 6] = {m_ex, m_pa};
    m_win = (m_ex == 3'd4);
    chk("done_count", 36'(ndone), 36'd1);
    chk("done_latency", 36'(at), 36'd8);
    chk("exact", 36'(bus.exact), 36'(m_ex));
    chk("partial", 36'(bus.partial), 36'(m_pa));
    chk("feedback_flat", bus.feedback_flat, m_fb);
    chk("win", 36'(bus.win), 36'(m_win));
    chk("busy_idle", 36'(bus.busy), 36'd0);
  endtask

  initial begin
    logic [11:0] g;
    logic [11:0] a;
    int ndone;

    Reset         = 1'b1;
    bus.clear     = 1'b0;
    bus.start     = 1'b0;
    bus.guess     = '0;
    bus.answer    = '0;
    bus.row       = '0;
    m_fb          = '0;
    m_win         = 1'b0;
    m_ex          = '0;
    m_pa          = '0;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_busy", 36'(bus.busy), 36'd0);
    chk("rst_done", 36'(bus.done), 36'd0);
    chk("rst_exact", 36'(bus.exact), 36'd0);
    chk("rst_partial", 36'(bus.partial), 36'd0);
    chk("rst_win", 36'(bus.win), 36'd0);
    chk("rst_fb", bus.feedback_flat, 36'd0);
    @(negedge Clk);
    Reset = 1'b0;

    eval(12'b001_010_001_011, 12'b001_001_001_001, 3'd0, 1'b0);
    chk("case1_slot0", 36'(bus.feedback_flat[5:0]), 36'b010_000);
    eval(12'b100_011_010_001, 12'b001_010_011_100, 3'd1, 1'b0);
    chk("case2_slot1", 36'(bus.feedback_flat[11:6]), 36'b000_100);
    eval(12'b011_001_001_010, 12'b010_010_001_001, 3'd2, 1'b0);
    chk("case3_exact", 36'(bus.exact), 36'd1);
    chk("case3_partial", 36'(bus.partial), 36'd2);
    eval(12'b010_010_001_001, 12'b010_010_001_001, 3'd5, 1'b0);
    chk("case3_slot5", 36'(bus.feedback_flat[35:30]), 36'b100_000);
    chk("case3_win", 36'(bus.win), 36'd1);
    eval(12'b000_000_000_000, 12'b000_001_010_011, 3'd3, 1'b0);
    eval(12'b111_111_000_000, 12'b111_111_000_000, 3'd4, 1'b0);
    eval(12'b001_010_011_100, 12'b001_010_011_101, 3'd3, 1'b1);
    eval(12'b110_101_100_011, 12'b011_100_101_110, 3'd6, 1'b0);
    eval(12'b110_110_110_110, 12'b110_110_110_110, 3'd7, 1'b0);

    @(negedge Clk);
    bus.clear  = 1'b1;
    bus.start  = 1'b1;
    bus.guess  = 12'b001_001_001_001;
    bus.answer = 12'b001_001_001_001;
    @(posedge Clk);
    #1;
    chk("clr_busy", 36'(bus.busy), 36'd0);
    chk("clr_exact", 36'(bus.exact), 36'd0);
    chk("clr_partial", 36'(bus.partial), 36'd0);
    chk("clr_win", 36'(bus.win), 36'd0);
    chk("clr_fb", bus.feedback_flat, 36'd0);
    @(negedge Clk);
    bus.clear = 1'b0;
    bus.start = 1'b0;
    m_fb  = '0;
    m_win = 1'b0;

    for (int t = 0; t < 40; t++) begin
      a = 12'($urandom);
      if ($urandom_range(0, 1) == 1)
        g = a ^ (12'($urandom) & 12'($urandom));
      else
        g = 12'($urandom);
      eval(g, a, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    end

    eval(12'b001_010_011_100, 12'b001_011_010_100, 3'd0, 1'b0);
    @(negedge Clk);
    bus.guess  = 12'b001_001_001_001;
    bus.answer = 12'b001_001_001_001;
    bus.row    = 3'd1;
    bus.start  = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    bus.start = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    Reset = 1'b1;
    #1;
    chk("abort_busy", 36'(bus.busy), 36'd0);
    ndone = 0;
    for (int n = 0; n < 8; n++) begin
      if (n == 2) Reset = 1'b0;
      @(posedge Clk);
      #1;
      if (bus.done) ndone++;
    end
    chk("abort_no_done", 36'(ndone), 36'd0);
    chk("abort_fb", bus.feedback_flat, 36'd0);
    chk("abort_win", 36'(bus.win), 36'd0);
    chk("abort_exact", 36'(bus.exact), 36'd0);
    m_fb  = '0;
    m_win = 1'b0;
    eval(12'b101_100_011_010, 12'b101_100_011_010, 3'd2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
